// File: rtl/iq_tx_pkg.sv
// Package: iq_tx_pkg
// Shared types and helpers for the I/Q symbol feeder.
//  - mode_e           : modulation mode (IQ8, QPSK, BPSK, CW)
//  - sym_state_e      : symbol FSM states
//  - fetch_state_e    : FIFO fetch engine states
//  - amp_a()          : full-scale amplitude 2^(w-1)-1 for a w-bit two's complement sample
//  - bits_per_symbol(): buffered bits consumed per symbol for a mode
package iq_tx_pkg;

  typedef enum logic [1:0] {
    MODE_IQ8  = 2'd0,
    MODE_QPSK = 2'd1,
    MODE_BPSK = 2'd2,
    MODE_CW   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } sym_state_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_CAP  = 2'd2
  } fetch_state_e;

  function automatic int unsigned amp_a(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

  function automatic logic [7:0] bits_per_symbol(input mode_e m, input int unsigned w);
    case (m)
      MODE_IQ8:  return 8'(2 * w);
      MODE_QPSK: return 8'd2;
      MODE_BPSK: return 8'd1;
      MODE_CW:   return 8'd0;
      default:   return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/iq_bit_buffer.sv
// Module: iq_bit_buffer
// 2*DATA_W-bit MSB-first bit buffer with its own FIFO fetch engine.
// Valid bits sit left-justified in bits[2*DATA_W-1 -: bit_cnt]; everything below is zero.
// Ports:
//  clk, rst     clock, asynchronous active-high reset
//  flush        synchronous clear of buffer and fetch engine (in-flight data dropped)
//  fetch_en     fetching allowed (feeder active, mode needs data)
//  consume      shift out consume_k bits this cycle
//  consume_k    bits per symbol
//  fifo_q       FIFO data, valid the cycle after fifo_rd
//  fifo_empty   FIFO empty flag
//  fifo_rd      registered one-cycle read request
//  bits         buffer contents (MSB = next bit)
//  bit_cnt      number of valid buffered bits
module iq_bit_buffer
  import iq_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int BUF_W = 2 * DATA_W,
  localparam int CNT_W = $clog2(BUF_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fetch_en,
  input  logic              consume,
  input  logic [CNT_W-1:0]  consume_k,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [BUF_W-1:0]  bits,
  output logic [CNT_W-1:0]  bit_cnt
);

  fetch_state_e      fstate_r;
  logic [BUF_W-1:0]  buf_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              fifo_rd_r;

  logic [BUF_W-1:0]  shifted_s;
  logic [BUF_W-1:0]  append_s;
  logic [BUF_W-1:0]  buf_next_s;
  logic [CNT_W-1:0]  cnt_after_s;
  logic [CNT_W-1:0]  cnt_next_s;

  assign fifo_rd = fifo_rd_r;
  assign bits    = buf_r;
  assign bit_cnt = bit_cnt_r;

  // Next buffer value: consume first, then append the captured word just below the remaining bits.
  always_comb begin
    shifted_s   = buf_r;
    cnt_after_s = bit_cnt_r;
    append_s    = {BUF_W{1'b0}};
    cnt_next_s  = bit_cnt_r;
    if (consume) begin
      shifted_s   = buf_r << consume_k;
      cnt_after_s = bit_cnt_r - consume_k;
    end else begin
      shifted_s   = buf_r;
      cnt_after_s = bit_cnt_r;
    end
    // A fetch only starts with bit_cnt <= DATA_W, so the appended word always fits.
    if (fstate_r == F_CAP) begin
      append_s   = {fifo_q, {DATA_W{1'b0}}} >> cnt_after_s;
      cnt_next_s = cnt_after_s + CNT_W'(DATA_W);
    end else begin
      append_s   = {BUF_W{1'b0}};
      cnt_next_s = cnt_after_s;
    end
    buf_next_s = shifted_s | append_s;
  end

  // Buffer state and fetch FSM; at most one read outstanding, never reads an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r     <= {BUF_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      fstate_r  <= F_IDLE;
      fifo_rd_r <= 1'b0;
    end else if (flush) begin
      buf_r     <= {BUF_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      fstate_r  <= F_IDLE;
      fifo_rd_r <= 1'b0;
    end else begin
      buf_r     <= buf_next_s;
      bit_cnt_r <= cnt_next_s;
      case (fstate_r)
        F_IDLE: begin
          if (fetch_en && !fifo_empty && (bit_cnt_r <= CNT_W'(DATA_W))) begin
            fstate_r  <= F_REQ;
            fifo_rd_r <= 1'b1;
          end else begin
            fstate_r  <= F_IDLE;
            fifo_rd_r <= 1'b0;
          end
        end
        F_REQ: begin
          fstate_r  <= F_CAP;
          fifo_rd_r <= 1'b0;
        end
        F_CAP: begin
          fstate_r  <= F_IDLE;
          fifo_rd_r <= 1'b0;
        end
        default: begin
          fstate_r  <= F_IDLE;
          fifo_rd_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/iq_symbol_feeder.sv
// Module: iq_symbol_feeder
// Drains the sample FIFO, unpacks bytes into I/Q symbols for the selected modulation and
// presents them to iq_mod at a programmable symbol rate.
// Ports:
//  clk, rst    system clock, asynchronous active-high reset
//  en          run enable; low = idle, buffer flushed, outputs zero
//  mode        modulation mode, latched on en rising edge
//  rate_div    symbol period = rate_div+1 clocks, sampled at every reload
//  fifo_q      FIFO read data; fifo_empty FIFO empty flag; fifo_rd read request pulse
//  i_mul/q_mul symbol outputs; sym_stb new-symbol pulse; underrun starved-boundary pulse
//  running     high in RUN state
module iq_symbol_feeder
  import iq_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [RATE_W-1:0] rate_div,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] i_mul,
  output logic [DATA_W-1:0] q_mul,
  output logic              sym_stb,
  output logic              underrun,
  output logic              running
);

  localparam int BUF_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [DATA_W-1:0] AMP     = DATA_W'(amp_a(DATA_W));
  localparam logic [DATA_W-1:0] NEG_AMP = -AMP;
  localparam logic [DATA_W-1:0] ZERO    = {DATA_W{1'b0}};
  localparam logic [RATE_W-1:0] PER_ONE = {{(RATE_W-1){1'b0}}, 1'b1};

  sym_state_e        state_r;
  mode_e             mode_r;
  logic              en_d_r;
  logic [RATE_W-1:0] per_cnt_r;
  logic [DATA_W-1:0] i_mul_r;
  logic [DATA_W-1:0] q_mul_r;
  logic              sym_stb_r;
  logic              underrun_r;
  logic              running_r;

  logic [BUF_W-1:0]  bits_s;
  logic [CNT_W-1:0]  bit_cnt_s;
  logic [CNT_W-1:0]  k_s;
  logic              have_bits_s;
  logic              boundary_s;
  logic              consume_s;
  logic              flush_s;
  logic              fetch_en_s;
  logic [DATA_W-1:0] sym_i_s;
  logic [DATA_W-1:0] sym_q_s;

  assign i_mul    = i_mul_r;
  assign q_mul    = q_mul_r;
  assign sym_stb  = sym_stb_r;
  assign underrun = underrun_r;
  assign running  = running_r;

  assign k_s         = CNT_W'(bits_per_symbol(mode_r, DATA_W));
  assign have_bits_s = (bit_cnt_s >= k_s);
  assign boundary_s  = (state_r == S_RUN) && (per_cnt_r == {RATE_W{1'b0}});
  assign consume_s   = en && boundary_s && have_bits_s;
  // The buffer is held empty whenever the feeder is (or is about to be) idle.
  assign flush_s     = !en || (state_r == S_IDLE);
  assign fetch_en_s  = (state_r != S_IDLE) && (mode_r != MODE_CW);

  iq_bit_buffer #(.DATA_W(DATA_W)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_s),
    .fetch_en   (fetch_en_s),
    .consume    (consume_s),
    .consume_k  (k_s),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .bits       (bits_s),
    .bit_cnt    (bit_cnt_s)
  );

  // Map the leading buffered bits to an I/Q symbol: bit 0 -> +A, bit 1 -> -A.
  always_comb begin
    sym_i_s = ZERO;
    sym_q_s = ZERO;
    case (mode_r)
      MODE_IQ8: begin
        sym_i_s = bits_s[BUF_W-1 -: DATA_W];
        sym_q_s = bits_s[DATA_W-1:0];
      end
      MODE_QPSK: begin
        sym_i_s = bits_s[BUF_W-1] ? NEG_AMP : AMP;
        sym_q_s = bits_s[BUF_W-2] ? NEG_AMP : AMP;
      end
      MODE_BPSK: begin
        sym_i_s = bits_s[BUF_W-1] ? NEG_AMP : AMP;
        sym_q_s = ZERO;
      end
      MODE_CW: begin
        sym_i_s = AMP;
        sym_q_s = ZERO;
      end
      default: begin
        sym_i_s = ZERO;
        sym_q_s = ZERO;
      end
    endcase
  end

  // Symbol FSM, period counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      mode_r     <= MODE_IQ8;
      en_d_r     <= 1'b0;
      per_cnt_r  <= {RATE_W{1'b0}};
      i_mul_r    <= ZERO;
      q_mul_r    <= ZERO;
      sym_stb_r  <= 1'b0;
      underrun_r <= 1'b0;
      running_r  <= 1'b0;
    end else begin
      en_d_r     <= en;
      sym_stb_r  <= 1'b0;
      underrun_r <= 1'b0;
      if (!en) begin
        state_r   <= S_IDLE;
        per_cnt_r <= {RATE_W{1'b0}};
        i_mul_r   <= ZERO;
        q_mul_r   <= ZERO;
        running_r <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            i_mul_r <= ZERO;
            q_mul_r <= ZERO;
            if (!en_d_r) begin
              mode_r    <= mode_e'(mode);
              per_cnt_r <= {RATE_W{1'b0}};
              if (mode_e'(mode) == MODE_CW) begin
                state_r   <= S_RUN;
                running_r <= 1'b1;
              end else begin
                state_r   <= S_PRIME;
                running_r <= 1'b0;
              end
            end else begin
              state_r   <= S_IDLE;
              running_r <= 1'b0;
            end
          end
          S_PRIME: begin
            // Counter at zero makes the very next cycle the first boundary.
            if (have_bits_s) begin
              state_r   <= S_RUN;
              running_r <= 1'b1;
              per_cnt_r <= {RATE_W{1'b0}};
            end else begin
              state_r   <= S_PRIME;
              running_r <= 1'b0;
            end
          end
          S_RUN: begin
            running_r <= 1'b1;
            if (per_cnt_r == {RATE_W{1'b0}}) begin
              per_cnt_r <= rate_div;
              if (have_bits_s) begin
                i_mul_r   <= sym_i_s;
                q_mul_r   <= sym_q_s;
                sym_stb_r <= 1'b1;
              end else begin
                i_mul_r    <= ZERO;
                q_mul_r    <= ZERO;
                underrun_r <= 1'b1;
              end
            end else begin
              per_cnt_r <= per_cnt_r - PER_ONE;
            end
          end
          default: begin
            state_r   <= S_IDLE;
            running_r <= 1'b0;
            i_mul_r   <= ZERO;
            q_mul_r   <= ZERO;
          end
        endcase
      end
    end
  end

endmodule
